// File: rtl/crack_sched.sv
// rtl/crack_sched.sv - round scheduler for a bank of parallel ARC4 key-search units
//
// Assigns each crack unit an interleaved key lane (lane i starts at base + i and
// steps by N_CRACK each round). It releases all units together with a common sync
// pulse once every unit is in standby. The first unit to report a key wins, and the
// other units are cancelled.
//
// Optional feature macro: CRACK_SCHED_ROUND_CNT_EN adds a 24-bit "rounds" output
// counting sync pulses since launch.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   en, rdy           search start request / scheduler idle
//   start_base        first key of the search, latched on an accepted en
//   done              search finished (key found or key space exhausted)
//   key, key_valid    winning key and its qualifier
//   winner            index of the winning unit
//   unit_en           per-unit launch pulse
//   unit_rdy          per-unit ready
//   unit_cancel       per-unit cancel pulse
//   unit_sync         common round-advance pulse
//   unit_standby      per-unit "current key rejected, waiting"
//   unit_start_key    lane start keys, slice [24i+23:24i]
//   key_increment     per-round key step (N_CRACK)
//   unit_key          per-unit reported key
//   unit_key_valid    per-unit key found
//   rounds            (optional) sync pulses since launch

module crack_sched #(
    parameter int N_CRACK = 2,
    parameter int IDX_W   = $clog2(N_CRACK)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    output logic                    rdy,
    input  logic [23:0]             start_base,
    output logic                    done,
    output logic [23:0]             key,
    output logic                    key_valid,
    output logic [IDX_W-1:0]        winner,
    output logic [N_CRACK-1:0]      unit_en,
    input  logic [N_CRACK-1:0]      unit_rdy,
    output logic [N_CRACK-1:0]      unit_cancel,
    output logic                    unit_sync,
    input  logic [N_CRACK-1:0]      unit_standby,
    output logic [24*N_CRACK-1:0]   unit_start_key,
    output logic [23:0]             key_increment,
    input  logic [24*N_CRACK-1:0]   unit_key,
    input  logic [N_CRACK-1:0]      unit_key_valid
`ifdef CRACK_SCHED_ROUND_CNT_EN
    ,
    output logic [23:0]             rounds
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_RDY,
        S_LAUNCH,
        S_RUN,
        S_SYNC,
        S_HOLD,
        S_FOUND,
        S_EXHAUSTED
    } state_t;

    state_t               state;
    state_t               state_n;
    logic [23:0]          base_q;
    logic [24:0]          cur_q;
    logic [24:0]          cur_step;
    logic [IDX_W-1:0]     win_idx;
    logic [23:0]          win_key;
    logic [N_CRACK-1:0]   cancel_n;

    // Bit 24 of the next round's base marks that the current round already
    // covers the last key of the 24-bit space.
    assign cur_step      = cur_q + 25'(N_CRACK);
    assign key_increment = 24'(N_CRACK);

    for (genvar i = 0; i < N_CRACK; i++) begin : g_lane
        assign unit_start_key[24*i +: 24] = base_q + 24'(i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        cancel_n = '0;
        win_idx  = '0;
        win_key  = '0;
        // Descending scan so the lowest set index is the one left standing.
        for (int i = N_CRACK - 1; i >= 0; i--) begin
            if (unit_key_valid[i]) begin
                win_idx = IDX_W'(i);
                win_key = unit_key[24*i +: 24];
            end
        end
        case (state)
            S_IDLE:     if (en) state_n = S_WAIT_RDY;
            S_WAIT_RDY: if (&unit_rdy) state_n = S_LAUNCH;
            S_LAUNCH:   state_n = S_RUN;
            S_RUN: begin
                // A reported key takes priority over a round ending in the same cycle.
                if (|unit_key_valid) begin
                    state_n  = S_FOUND;
                    cancel_n = ~(N_CRACK'(1) << win_idx);
                end else if (&unit_standby) begin
                    if (cur_step[24]) begin
                        state_n  = S_EXHAUSTED;
                        cancel_n = '1;
                    end else begin
                        state_n = S_SYNC;
                    end
                end
            end
            S_SYNC:     state_n = S_HOLD;
            // HOLD gives the units a cycle to drop standby before RUN looks again.
            S_HOLD:     state_n = S_RUN;
            default:    state_n = state;
        endcase
    end

    // Outputs are registered from the next state so each pulse lines up with
    // the cycle the FSM spends in the corresponding state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy         <= 1'b1;
            done        <= 1'b0;
            key         <= '0;
            key_valid   <= 1'b0;
            winner      <= '0;
            unit_en     <= '0;
            unit_cancel <= '0;
            unit_sync   <= 1'b0;
            base_q      <= '0;
            cur_q       <= '0;
        end else begin
            rdy         <= (state_n == S_IDLE);
            done        <= (state_n == S_FOUND) || (state_n == S_EXHAUSTED);
            key_valid   <= (state_n == S_FOUND);
            unit_en     <= (state_n == S_LAUNCH) ? '1 : '0;
            unit_sync   <= (state_n == S_SYNC);
            unit_cancel <= cancel_n;
            if (state == S_IDLE && en) begin
                base_q <= start_base;
                cur_q  <= {1'b0, start_base};
            end else if (state_n == S_SYNC) begin
                cur_q <= cur_step;
            end
            if (state == S_RUN && state_n == S_FOUND) begin
                key    <= win_key;
                winner <= win_idx;
            end
        end
    end

`ifdef CRACK_SCHED_ROUND_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rounds <= '0;
        end else if (state_n == S_LAUNCH) begin
            rounds <= '0;
        end else if (state_n == S_SYNC) begin
            rounds <= rounds + 24'd1;
        end
    end
`endif

endmodule

// File: tb/tb_crack_sched.sv
// tb/tb_crack_sched.sv - table-driven testbench for crack_sched

module tb_crack_sched;

    localparam int N = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          rdy;
    logic [23:0]   start_base;
    logic          done;
    logic [23:0]   key;
    logic          key_valid;
    logic [0:0]    winner;
    logic [1:0]    unit_en;
    logic [1:0]    unit_rdy;
    logic [1:0]    unit_cancel;
    logic          unit_sync;
    logic [1:0]    unit_standby;
    logic [47:0]   unit_start_key;
    logic [23:0]   key_increment;
    logic [47:0]   unit_key;
    logic [1:0]    unit_key_valid;
`ifdef CRACK_SCHED_ROUND_CNT_EN
    logic [23:0]   rounds;
`endif

    always #5 clk = ~clk;

    crack_sched #(.N_CRACK(N)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (en),
        .rdy            (rdy),
        .start_base     (start_base),
        .done           (done),
        .key            (key),
        .key_valid      (key_valid),
        .winner         (winner),
        .unit_en        (unit_en),
        .unit_rdy       (unit_rdy),
        .unit_cancel    (unit_cancel),
        .unit_sync      (unit_sync),
        .unit_standby   (unit_standby),
        .unit_start_key (unit_start_key),
        .key_increment  (key_increment),
        .unit_key       (unit_key),
        .unit_key_valid (unit_key_valid)
`ifdef CRACK_SCHED_ROUND_CNT_EN
        ,
        .rounds         (rounds)
`endif
    );

    typedef struct {
        logic        rst;
        logic        en;
        logic [23:0] base;
        logic [1:0]  urdy;
        logic [1:0]  stby;
        logic [1:0]  ukv;
        logic [23:0] k1;
        logic [23:0] k0;
        logic        e_rdy;
        logic        e_done;
        logic        e_kv;
        logic        e_win;
        logic [23:0] e_key;
        logic [1:0]  e_uen;
        logic [1:0]  e_canc;
        logic        e_sync;
        logic [47:0] e_sk;
        logic        chk_cur;
        logic [24:0] e_cur;
        logic        mid_rst;
    } vec_t;

    vec_t vecs[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    function automatic vec_t mk(input int rst, input int en_i, input int base,
                                input int urdy, input int stby, input int ukv,
                                input int k1, input int k0,
                                input int e_rdy, input int e_done, input int e_kv,
                                input int e_win, input int e_key, input int e_uen,
                                input int e_canc, input int e_sync,
                                input int sk1, input int sk0,
                                input int chk_cur, input int e_cur, input int mid_rst);
        vec_t v;
        v.rst     = 1'(rst);
        v.en      = 1'(en_i);
        v.base    = 24'(base);
        v.urdy    = 2'(urdy);
        v.stby    = 2'(stby);
        v.ukv     = 2'(ukv);
        v.k1      = 24'(k1);
        v.k0      = 24'(k0);
        v.e_rdy   = 1'(e_rdy);
        v.e_done  = 1'(e_done);
        v.e_kv    = 1'(e_kv);
        v.e_win   = 1'(e_win);
        v.e_key   = 24'(e_key);
        v.e_uen   = 2'(e_uen);
        v.e_canc  = 2'(e_canc);
        v.e_sync  = 1'(e_sync);
        v.e_sk    = {24'(sk1), 24'(sk0)};
        v.chk_cur = 1'(chk_cur);
        v.e_cur   = 25'(e_cur);
        v.mid_rst = 1'(mid_rst);
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " rdy"},         64'(rdy),            64'd1);
        check({tag, " done"},        64'(done),           64'd0);
        check({tag, " key"},         64'(key),            64'd0);
        check({tag, " key_valid"},   64'(key_valid),      64'd0);
        check({tag, " winner"},      64'(winner),         64'd0);
        check({tag, " unit_en"},     64'(unit_en),        64'd0);
        check({tag, " unit_cancel"}, 64'(unit_cancel),    64'd0);
        check({tag, " unit_sync"},   64'(unit_sync),      64'd0);
        check({tag, " start_key"},   64'(unit_start_key), 64'h000001_000000);
        check({tag, " cur_q"},       64'(dut.cur_q),      64'd0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string t;
        t = $sformatf("v%0d", idx);
        @(negedge clk);
        en             = v.en;
        start_base     = v.base;
        unit_rdy       = v.urdy;
        unit_standby   = v.stby;
        unit_key_valid = v.ukv;
        unit_key       = {v.k1, v.k0};
        if (v.rst) begin
            rst_n = 1'b0;
            #2;
            rst_n = 1'b1;
        end
        @(posedge clk);
        #1;
        check({t, " rdy"},         64'(rdy),            64'(v.e_rdy));
        check({t, " done"},        64'(done),           64'(v.e_done));
        check({t, " key_valid"},   64'(key_valid),      64'(v.e_kv));
        check({t, " winner"},      64'(winner),         64'(v.e_win));
        check({t, " key"},         64'(key),            64'(v.e_key));
        check({t, " unit_en"},     64'(unit_en),        64'(v.e_uen));
        check({t, " unit_cancel"}, 64'(unit_cancel),    64'(v.e_canc));
        check({t, " unit_sync"},   64'(unit_sync),      64'(v.e_sync));
        check({t, " start_key"},   64'(unit_start_key), 64'(v.e_sk));
        check({t, " key_inc"},     64'(key_increment),  64'd2);
        if (v.chk_cur) begin
            check({t, " cur_q"}, 64'(dut.cur_q), 64'(v.e_cur));
        end
        if (v.mid_rst) begin
            // Asynchronous reset between clock edges while a sync pulse is high.
            #2;
            rst_n = 1'b0;
            #1;
            check_reset_outputs({t, " midrst"});
            rst_n = 1'b1;
        end
    endtask

    initial begin
        //           rst en base      urdy stby ukv k1     k0      rdy dn kv w key     uen cn sy sk1       sk0       cc cur        mr
        // Base 0: launch, one round, unit 1 finds the key
        vecs.push_back(mk(0, 1, 'h0,      0, 0, 0, 'h0,  'h0,    0, 0, 0, 0, 'h0,  0, 0, 0, 'h1,      'h0,      1, 'h0,       0));
        vecs.push_back(mk(0, 0, 'h0,      1, 0, 0, 'h0,  'h0,    0, 0, 0, 0, 'h0,  0, 0, 0, 'h1,      'h0,      0, 0,         0));
        vecs.push_back(mk(0, 0, 'h0,      3, 0, 0, 'h0,  'h0,    0, 0, 0, 0, 'h0,  3, 0, 0, 'h1,      'h0,      0, 0,         0));
        vecs.push_back(mk(0, 0, 'h0,      3, 0, 0, 'h0,  'h0,    0, 0, 0, 0, 'h0,  0, 0, 0, 'h1,      'h0,      0, 0,         0));
        vecs.push_back(mk(0, 0, 'h0,      3, 1, 0, 'h0,  'h0,    0, 0, 0, 0, 'h0,  0, 0, 0, 'h1,      'h0,      0, 0,         0));
        vecs.push_back(mk(0, 0, 'h0,      3, 3, 0, 'h0,  'h0,    0, 0, 0, 0, 'h0,  0, 0, 1, 'h1,      'h0,      0, 0,         0));
        vecs.push_back(mk(0, 0, 'h0,      3, 0, 0, 'h0,  'h0,    0, 0, 0, 0, 'h0,  0, 0, 0, 'h1,      'h0,      0, 0,         0));
        vecs.push_back(mk(0, 0, 'h0,      3, 0, 0, 'h0,  'h0,    0, 0, 0, 0, 'h0,  0, 0, 0, 'h1,      'h0,      1, 'h2,       0));
        vecs.push_back(mk(0, 0, 'h0,      3, 0, 2, 'hB,  'h5,    0, 1, 1, 1, 'hB,  0, 1, 0, 'h1,      'h0,      0, 0,         0));
        vecs.push_back(mk(0, 0, 'h0,      3, 0, 0, 'h77, 'h5,    0, 1, 1, 1, 'hB,  0, 0, 0, 'h1,      'h0,      0, 0,         0));
        vecs.push_back(mk(0, 1, 'h40,     3, 0, 0, 'h0,  'h0,    0, 1, 1, 1, 'hB,  0, 0, 0, 'h1,      'h0,      0, 0,         0));
        // Base 0x10: both units report a key while in standby; unit 0 wins, no sync
        vecs.push_back(mk(1, 1, 'h10,     3, 0, 0, 'h0,  'h0,    0, 0, 0, 0, 'h0,  0, 0, 0, 'h11,     'h10,     1, 'h10,      0));
        vecs.push_back(mk(0, 0, 'h10,     3, 0, 0, 'h0,  'h0,    0, 0, 0, 0, 'h0,  3, 0, 0, 'h11,     'h10,     0, 0,         0));
        vecs.push_back(mk(0, 0, 'h10,     3, 0, 0, 'h0,  'h0,    0, 0, 0, 0, 'h0,  0, 0, 0, 'h11,     'h10,     0, 0,         0));
        vecs.push_back(mk(0, 0, 'h10,     3, 3, 3, 'h22, 'h33,   0, 1, 1, 0, 'h33, 0, 2, 0, 'h11,     'h10,     0, 0,         0));
        vecs.push_back(mk(0, 0, 'h10,     3, 3, 0, 'h22, 'h33,   0, 1, 1, 0, 'h33, 0, 0, 0, 'h11,     'h10,     0, 0,         0));
        // Base 0xFFFFFA: three all-standby rounds, two syncs, then key space exhausted
        vecs.push_back(mk(1, 1, 'hFFFFFA, 0, 0, 0, 'h0,  'h0,    0, 0, 0, 0, 'h0,  0, 0, 0, 'hFFFFFB, 'hFFFFFA, 0, 0,         0));
        vecs.push_back(mk(0, 0, 'hFFFFFA, 3, 0, 0, 'h0,  'h0,    0, 0, 0, 0, 'h0,  3, 0, 0, 'hFFFFFB, 'hFFFFFA, 0, 0,         0));
        vecs.push_back(mk(0, 0, 'hFFFFFA, 3, 0, 0, 'h0,  'h0,    0, 0, 0, 0, 'h0,  0, 0, 0, 'hFFFFFB, 'hFFFFFA, 0, 0,         0));
        vecs.push_back(mk(0, 0, 'hFFFFFA, 3, 3, 0, 'h0,  'h0,    0, 0, 0, 0, 'h0,  0, 0, 1, 'hFFFFFB, 'hFFFFFA, 0, 0,         0));
        vecs.push_back(mk(0, 0, 'hFFFFFA, 3, 0, 0, 'h0,  'h0,    0, 0, 0, 0, 'h0,  0, 0, 0, 'hFFFFFB, 'hFFFFFA, 0, 0,         0));
        vecs.push_back(mk(0, 0, 'hFFFFFA, 3, 0, 0, 'h0,  'h0,    0, 0, 0, 0, 'h0,  0, 0, 0, 'hFFFFFB, 'hFFFFFA, 1, 'hFFFFFC,  0));
        vecs.push_back(mk(0, 0, 'hFFFFFA, 3, 3, 0, 'h0,  'h0,    0, 0, 0, 0, 'h0,  0, 0, 1, 'hFFFFFB, 'hFFFFFA, 0, 0,         0));
        vecs.push_back(mk(0, 0, 'hFFFFFA, 3, 0, 0, 'h0,  'h0,    0, 0, 0, 0, 'h0,  0, 0, 0, 'hFFFFFB, 'hFFFFFA, 0, 0,         0));
        vecs.push_back(mk(0, 0, 'hFFFFFA, 3, 0, 0, 'h0,  'h0,    0, 0, 0, 0, 'h0,  0, 0, 0, 'hFFFFFB, 'hFFFFFA, 1, 'hFFFFFE,  0));
        vecs.push_back(mk(0, 0, 'hFFFFFA, 3, 3, 0, 'h0,  'h0,    0, 1, 0, 0, 'h0,  0, 3, 0, 'hFFFFFB, 'hFFFFFA, 0, 0,         0));
        vecs.push_back(mk(0, 0, 'hFFFFFA, 3, 0, 0, 'h0,  'h0,    0, 1, 0, 0, 'h0,  0, 0, 0, 'hFFFFFB, 'hFFFFFA, 0, 0,         0));
        // Base 0x20: reset asserted mid-search during a sync pulse
        vecs.push_back(mk(1, 1, 'h20,     0, 0, 0, 'h0,  'h0,    0, 0, 0, 0, 'h0,  0, 0, 0, 'h21,     'h20,     0, 0,         0));
        vecs.push_back(mk(0, 0, 'h20,     3, 0, 0, 'h0,  'h0,    0, 0, 0, 0, 'h0,  3, 0, 0, 'h21,     'h20,     0, 0,         0));
        vecs.push_back(mk(0, 0, 'h20,     3, 0, 0, 'h0,  'h0,    0, 0, 0, 0, 'h0,  0, 0, 0, 'h21,     'h20,     0, 0,         0));
        vecs.push_back(mk(0, 0, 'h20,     3, 3, 0, 'h0,  'h0,    0, 0, 0, 0, 'h0,  0, 0, 1, 'h21,     'h20,     0, 0,         1));
        // Clean search after the mid-run reset
        vecs.push_back(mk(0, 1, 'h30,     0, 0, 0, 'h0,  'h0,    0, 0, 0, 0, 'h0,  0, 0, 0, 'h31,     'h30,     1, 'h30,      0));
        vecs.push_back(mk(0, 0, 'h30,     3, 0, 0, 'h0,  'h0,    0, 0, 0, 0, 'h0,  3, 0, 0, 'h31,     'h30,     0, 0,         0));
        vecs.push_back(mk(0, 0, 'h30,     3, 0, 0, 'h0,  'h0,    0, 0, 0, 0, 'h0,  0, 0, 0, 'h31,     'h30,     0, 0,         0));
        vecs.push_back(mk(0, 0, 'h30,     3, 0, 1, 'h0,  'h31,   0, 1, 1, 0, 'h31, 0, 2, 0, 'h31,     'h30,     0, 0,         0));

        rst_n          = 1'b0;
        en             = 1'b0;
        start_base     = '0;
        unit_rdy       = '0;
        unit_standby   = '0;
        unit_key_valid = '0;
        unit_key       = '0;
        #12;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], i);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
